seq_adder: RTL and testbench

Parametrised multi-cycle binary adder that adds two WIDTH-bit operands plus a carry-in, processing DIGIT bits per clock from LSB to MSB. It is the sequential successor to the team's single-bit half-adder cell. It trades latency for a short carry chain (DIGIT bits per cycle), for datapaths where a full WIDTH-bit ripple carry cannot close timing. A start/ready/done handshake controls it, and its result is held until the next operation completes.

---
 rtl/seq_adder_pkg.sv | 23 ++
 rtl/seq_adder_digit_adder.sv | 27 ++
 rtl/seq_adder.sv | 118 +++++++++++
 tb/tb_seq_adder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package seq_adder_pkg;

    // Controller states: waiting for work, or stepping through the digits.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    // Width of the digit counter: clog2(n) with a floor of one bit so a
    // single-digit configuration still has a legal counter register.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from single-bit full-adder cells.
// This is the only carry chain in the datapath, so its length sets the clock.
module digit_adder
    import seq_adder_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] carry_s;

    assign carry_s[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        // One full-adder cell: sum bit plus generate/propagate carry.
        assign s[i]           = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign co = carry_s[DIGIT];

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder: {cout,sum} = a + b + cin, DIGIT bits per clock, LSB
// first, with a start/ready/done handshake. Results are held on the ports
// until the next operation completes; partial results stay internal.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    // Reject configurations that cannot be split into whole digits.
    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $error("seq_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
    end
    if ((DIGIT < 1) || (DIGIT > WIDTH)) begin : g_bad_digit
        $error("seq_adder: DIGIT (%0d) must lie in 1..WIDTH (%0d)", DIGIT, WIDTH);
    end

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             carry_r;

    logic [DIGIT-1:0] dig_s;
    logic             co_s;
    logic [WIDTH-1:0] dig_ext_s;
    logic [WIDTH-1:0] res_next_s;

    // The low digit of each operand shift register is the digit in flight.
    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a  (a_sh_r[DIGIT-1:0]),
        .b  (b_sh_r[DIGIT-1:0]),
        .ci (carry_r),
        .s  (dig_s),
        .co (co_s)
    );

    // Insert the new digit at the top of the result so that after N steps
    // the first (least significant) digit has reached bit 0.
    always_comb begin
        dig_ext_s                = '0;
        dig_ext_s[DIGIT-1:0]     = dig_s;
        res_next_s               = (res_r >> DIGIT) | (dig_ext_s << (WIDTH - DIGIT));
    end

    // Controller and datapath: accept, step through N digits, publish result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            cnt_r   <= '0;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= ADD;
                        ready   <= 1'b0;
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= cin;
                        res_r   <= '0;
                        cnt_r   <= '0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                ADD: begin
                    a_sh_r  <= a_sh_r >> DIGIT;
                    b_sh_r  <= b_sh_r >> DIGIT;
                    res_r   <= res_next_s;
                    carry_r <= co_s;
                    if (cnt_r == CW'(N - 1)) begin
                        state_r <= IDLE;
                        ready   <= 1'b1;
                        done    <= 1'b1;
                        sum     <= res_next_s;
                        cout    <= co_s;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready   <= 1'b1;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder: a vector table on the 16/4 configuration,
// hand-written sequences for the handshake corner cases, and a 8/8 instance.
module tb_seq_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        ready;
    logic [15:0] sum;
    logic        cout;
    logic        done;

    logic        rst8;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        ready8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        done8;

    int n_tests;
    int n_fail;

    seq_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .sum(sum), .cout(cout), .done(done)
    );

    seq_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .sum(sum8), .cout(cout8), .done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start one operation from an idle, post-edge point; return the result
    // seen with done and the number of edges from acceptance to done.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tcin,
                         output logic [15:0] rs, output logic rc, output int lat);
        start = 1'b1; a = ta; b = tb_v; cin = tcin;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        check("busy_after_accept", {31'd0, ready}, 32'd0);
        lat = -1; rs = 16'hxxxx; rc = 1'bx;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = cyc; rs = sum; rc = cout;
                check("ready_with_done", {31'd0, ready}, 32'd1);
                break;
            end
        end
        if (lat < 0) begin
            n_tests++; n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 20 cycles");
        end
        @(posedge clk); #1;
        check("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    logic [15:0] rs;
    logic        rc;
    int          lat;
    int          ndone;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; rst8 = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

        @(posedge clk); #1;
        check("rst_ready",  {31'd0, ready}, 32'd1);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_sum",    {16'd0, sum},   32'd0);
        check("rst_cout",   {31'd0, cout},  32'd0);
        check("rst8_ready", {31'd0, ready8}, 32'd1);
        check("rst8_sum",   {24'd0, sum8},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0; rst8 = 1'b0;
        @(posedge clk); #1;

        // Table of independent operations.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, rs, rc, lat);
            check($sformatf("vec%0d_sum", i),  {16'd0, rs}, {16'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].exp_cout});
            check($sformatf("vec%0d_lat", i),  lat, 32'd4);
        end

        // start while busy is ignored: exactly one done, first operands win.
        start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        @(posedge clk); #1;                       // E0+1
        start = 1'b1; a = 16'hAAAA; b = 16'h1111;
        @(posedge clk); #1;                       // E0+2 sampled here
        start = 1'b0;
        ndone = 0; rs = 16'h0000;
        for (int cyc = 3; cyc <= 14; cyc++) begin
            if (done) begin ndone++; rs = sum; end
            @(posedge clk); #1;
        end
        check("busy_start_ndone", ndone, 32'd1);
        check("busy_start_sum", {16'd0, rs}, 32'h5555);
        check("busy_start_ready", {31'd0, ready}, 32'd1);

        // Asynchronous reset in the middle of an operation.
        start = 1'b1; a = 16'h0F00; b = 16'h0100; cin = 1'b0;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;                       // E0+2
        rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_sum",   {16'd0, sum},   32'd0);
        check("abort_cout",  {31'd0, cout},  32'd0);
        check("abort_done",  {31'd0, done},  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 32'd0);
        do_op(16'h0F00, 16'h0100, 1'b0, rs, rc, lat);
        check("after_abort_sum", {16'd0, rs}, 32'h1000);
        check("after_abort_lat", lat, 32'd4);

        // Back-to-back: start held through the done cycle.
        start = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        @(posedge clk); #1;                       // E0
        lat = -1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            if (done) begin lat = cyc; rs = sum; break; end
        end
        check("b2b_first_lat", lat, 32'd4);
        check("b2b_first_sum", {16'd0, rs}, 32'h0003);
        a = 16'h0F0F; b = 16'hF0F0;               // start still high
        @(posedge clk); #1;                       // E0+5: second accepted
        start = 1'b0;
        check("b2b_accept", {31'd0, ready}, 32'd0);
        lat = -1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            if (done) begin lat = cyc; rs = sum; rc = cout; break; end
            if (cyc == 3) check("b2b_hold_sum", {16'd0, sum}, 32'h0003);
        end
        check("b2b_second_lat",  lat, 32'd4);
        check("b2b_second_sum",  {16'd0, rs}, 32'hFFFF);
        check("b2b_second_cout", {31'd0, rc}, 32'd0);

        // Single-digit configuration: done one edge after acceptance.
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("n1_busy", {31'd0, ready8}, 32'd0);
        @(posedge clk); #1;
        check("n1_done", {31'd0, done8}, 32'd1);
        check("n1_sum",  {24'd0, sum8},  32'h00);
        check("n1_cout", {31'd0, cout8}, 32'd1);
        start8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("n1_gap_done", {31'd0, done8}, 32'd0);
        @(posedge clk); #1;
        check("n1b_done", {31'd0, done8}, 32'd1);
        check("n1b_sum",  {24'd0, sum8},  32'h81);
        check("n1b_cout", {31'd0, cout8}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
